proj_out_stage: RTL

- Registered output stage directly downstream of the 13-input project output mux; consumes the 16-bit selected word and the 4-bit project select.
- Drives the registered pad word, blanks the pads for a fixed window after every select change, and logs value changes into a small FIFO read by the management side with a valid/ready handshake.

---
 rtl/proj_out_pkg.sv | 21 ++
 rtl/proj_out_fifo.sv | 63 ++++++
 rtl/proj_out_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/proj_out_pkg.sv
// Shared types for the project output stage: default widths, FSM state encoding
// and the log entry layout carried through the change-log FIFO.
package proj_out_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int SEL_W_DEF  = 4;
    localparam int STAMP_W    = 16;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [SEL_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
        logic [STAMP_W-1:0]    stamp;
    } entry_t;

endpackage

// File: rtl/proj_out_fifo.sv
// Synchronous FIFO of log entries. Pops only when non-empty; a push while full
// is accepted only if a pop frees a slot in the same cycle.
module proj_out_fifo
    import proj_out_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  entry_t        wr_entry,
    output entry_t        rd_entry,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CW'(DEPTH));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_entry  = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/proj_out_stage.sv
// Registered pad stage behind the project mux: blanks pads after a select change
// and logs word changes. Define PROJ_OUT_STAGE_TIMESTAMP_EN to stamp log entries.
module proj_out_stage
    import proj_out_pkg::*;
#(
    parameter  int DATA_W       = DATA_W_DEF,
    parameter  int SEL_W        = SEL_W_DEF,
    parameter  int DEPTH        = 8,
    parameter  int BLANK_CYCLES = 4,
    localparam int CW           = $clog2(DEPTH) + 1,
    localparam int BW           = $clog2(BLANK_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_in,
    input  logic              freeze,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] io_out_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_tag,
    output logic [15:0]       out_stamp,
    output logic [CW-1:0]     fifo_count,
    output logic              overflow,
    output logic [1:0]        state_o
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [SEL_W-1:0]  sel_q_r;
    logic [BW-1:0]     blank_cnt_r;
    logic              baseline_r;
    logic [DATA_W-1:0] last_r;
    logic              ovf_r;
    logic              change_s;
    logic              blank_last_s;
    logic              sample_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic [15:0]       stamp_s;
    entry_t            wr_entry_s;
    entry_t            rd_entry_s;
    logic              full_s;
    logic              empty_s;

    assign change_s     = (sel != sel_q_r);
    assign blank_last_s = (blank_cnt_r == BW'(1));

`ifdef PROJ_OUT_STAGE_TIMESTAMP_EN
    logic [15:0] stamp_r;

    // Free-running cycle counter sampled into each log entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stamp_r <= 16'd0;
        end else begin
            stamp_r <= stamp_r + 16'd1;
        end
    end

    assign stamp_s = stamp_r;
`else
    assign stamp_s = 16'd0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a select change overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        if (change_s) begin
            state_nxt_s = ST_BLANK;
        end else begin
            case (state_r)
                ST_BLANK: begin
                    if (blank_last_s) begin
                        state_nxt_s = freeze ? ST_HOLD : ST_RUN;
                    end else begin
                        state_nxt_s = ST_BLANK;
                    end
                end
                ST_RUN:  state_nxt_s = freeze ? ST_HOLD : ST_RUN;
                ST_HOLD: state_nxt_s = freeze ? ST_HOLD : ST_RUN;
                default: state_nxt_s = ST_BLANK;
            endcase
        end
    end

    // Output decode: freeze takes effect in the same cycle it is raised.
    always_comb begin
        sample_s = 1'b0;
        push_s   = 1'b0;
        if (!change_s && (state_r == ST_RUN) && !freeze) begin
            sample_s = 1'b1;
            push_s   = baseline_r | (mux_in != last_r);
        end else begin
            sample_s = 1'b0;
            push_s   = 1'b0;
        end
    end

    assign pop_s  = ~empty_s & out_ready;
    assign drop_s = push_s & full_s & ~pop_s;

    // Pad word, blank counter, change-compare reference and baseline request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q_r     <= {SEL_W{1'b0}};
            io_out_q    <= {DATA_W{1'b0}};
            blank_cnt_r <= BW'(BLANK_CYCLES);
            baseline_r  <= 1'b1;
            last_r      <= {DATA_W{1'b0}};
        end else begin
            sel_q_r <= sel;
            if (change_s || (state_r == ST_BLANK)) begin
                io_out_q <= {DATA_W{1'b0}};
            end else if (sample_s) begin
                io_out_q <= mux_in;
            end
            if (change_s) begin
                blank_cnt_r <= BW'(BLANK_CYCLES);
            end else if ((state_r == ST_BLANK) && !blank_last_s) begin
                blank_cnt_r <= blank_cnt_r - BW'(1);
            end
            if (change_s || (state_r == ST_BLANK)) begin
                baseline_r <= 1'b1;
            end else if (sample_s) begin
                baseline_r <= 1'b0;
            end
            if (sample_s) begin
                last_r <= mux_in;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (clr_ovf) begin
            ovf_r <= 1'b0;
        end
    end

    assign wr_entry_s.tag   = sel;
    assign wr_entry_s.data  = mux_in;
    assign wr_entry_s.stamp = stamp_s;

    proj_out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_s),
        .pop      (pop_s),
        .wr_entry (wr_entry_s),
        .rd_entry (rd_entry_s),
        .full     (full_s),
        .empty    (empty_s),
        .count    (fifo_count)
    );

    assign out_valid = ~empty_s;
    assign out_data  = out_valid ? rd_entry_s.data  : {DATA_W{1'b0}};
    assign out_tag   = out_valid ? rd_entry_s.tag   : {SEL_W{1'b0}};
    assign out_stamp = out_valid ? rd_entry_s.stamp : 16'd0;
    assign overflow  = ovf_r;
    assign state_o   = state_r;

endmodule
